// File: rtl/key_pkg.sv
// Shared definitions for the key debounce front end: FSM encoding and debounce window constants.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILT_DN = 2'd1,
    DOWN    = 2'd2,
    FILT_UP = 2'd3
  } key_fsm_e;

  // Debounce window minus one: 20 ms at 50 MHz, and a short window for simulation.
  localparam int unsigned CNT_MAX_50M = 999_999;
  localparam int unsigned CNT_MAX_SIM = 9;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser for the raw key plus a history flop for edge detection.
module key_sync_edge (
  input  logic clock,
  input  logic rst_n,
  input  logic key_in,
  output logic nedge,
  output logic pedge,
  output logic s2
);

  logic s1;
  logic s3;

  // Reset to released so a key held through reset still shows a falling edge.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= key_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign nedge = s3 & ~s2;
  assign pedge = ~s3 & s2;

endmodule

// File: rtl/key_pulse_filter.sv
// Debounces an active-low key into level, edge-flag and press-pulse outputs.
// Optional auto-repeat of press_pulse while held is enabled by defining KEY_REPEAT_EN.
module key_pulse_filter
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX       = CNT_MAX_50M
`ifdef KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_FIRST  = 24_999_999,
  parameter int unsigned REPEAT_PERIOD = 4_999_999
`endif
) (
  input  logic clock,
  input  logic rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  logic nedge;
  logic pedge;
  logic key_sync;

  key_sync_edge u_sync (
    .clock  (clock),
    .rst_n  (rst_n),
    .key_in (key_in),
    .nedge  (nedge),
    .pedge  (pedge),
    .s2     (key_sync)
  );

  key_fsm_e   state;
  key_fsm_e   state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic       key_flag_nxt;
  logic       key_state_nxt;
  logic       press_pulse_nxt;
  logic       cnt_done;

  assign cnt_done = (cnt == CNT_W'(CNT_MAX));

`ifdef KEY_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_FIRST > REPEAT_PERIOD) ? REPEAT_FIRST : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt;
  logic [RPT_W-1:0] rpt_cnt_nxt;
  logic             rpt_first;
  logic             rpt_first_nxt;
  logic             rpt_hit;

  assign rpt_hit = (rpt_cnt == (rpt_first ? RPT_W'(REPEAT_FIRST) : RPT_W'(REPEAT_PERIOD)));
`endif

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_flag    <= 1'b0;
      key_state   <= 1'b1;
      press_pulse <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt     <= '0;
      rpt_first   <= 1'b1;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_flag    <= key_flag_nxt;
      key_state   <= key_state_nxt;
      press_pulse <= press_pulse_nxt;
`ifdef KEY_REPEAT_EN
      rpt_cnt     <= rpt_cnt_nxt;
      rpt_first   <= rpt_first_nxt;
`endif
    end
  end

  // Opposing edges are checked before window expiry so a bounce on the last count wins.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    key_flag_nxt    = 1'b0;
    key_state_nxt   = key_state;
    press_pulse_nxt = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_cnt_nxt     = '0;
    rpt_first_nxt   = 1'b1;
`endif
    case (state)
      IDLE: begin
        key_state_nxt = 1'b1;
        if (nedge) state_nxt = FILT_DN;
      end
      FILT_DN: begin
        if (pedge) begin
          state_nxt = IDLE;
        end else if (cnt_done && !key_sync) begin
          state_nxt       = DOWN;
          key_flag_nxt    = 1'b1;
          press_pulse_nxt = 1'b1;
          key_state_nxt   = 1'b0;
        end else if (!cnt_done) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        if (pedge) begin
          state_nxt = FILT_UP;
        end
`ifdef KEY_REPEAT_EN
        else if (rpt_hit) begin
          press_pulse_nxt = 1'b1;
          rpt_cnt_nxt     = '0;
          rpt_first_nxt   = 1'b0;
        end else begin
          rpt_cnt_nxt   = rpt_cnt + RPT_W'(1);
          rpt_first_nxt = rpt_first;
        end
`endif
      end
      FILT_UP: begin
        if (nedge) begin
          state_nxt = DOWN;
        end else if (cnt_done && key_sync) begin
          state_nxt     = IDLE;
          key_flag_nxt  = 1'b1;
          key_state_nxt = 1'b1;
        end else if (!cnt_done) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

endmodule

// File: tb/tb_key_pulse_filter.sv
// Bench for key_pulse_filter: directed scenarios plus random key waveforms against a run-length model.
module tb_key_pulse_filter;
  import key_pkg::*;

  localparam int unsigned CM = CNT_MAX_SIM;
  // Samples of the new level needed before a flip: window plus the two synchroniser stages.
  localparam int unsigned RUN_NEED = CM + 2;
`ifdef KEY_REPEAT_EN
  localparam int unsigned RF = 19;
  localparam int unsigned RP = 4;
`endif

  logic clock = 1'b0;
  logic rst_n;
  logic key_in;
  logic key_flag;
  logic key_state;
  logic press_pulse;

  always #5 clock = ~clock;

  key_pulse_filter #(
    .CNT_MAX       (CM)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_FIRST  (RF),
    .REPEAT_PERIOD (RP)
`endif
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .key_in      (key_in),
    .key_flag    (key_flag),
    .key_state   (key_state),
    .press_pulse (press_pulse)
  );

  int errors = 0;
  int checks = 0;
  int edge_no = 0;
  int flag_cnt = 0;
  int pulse_cnt = 0;
  int last_flag_edge = 0;
  int cout_cnt = 0;
  int e0;
  logic [3:0] q = 4'd0;

  // Reference: debounced level L flips once the delayed raw input has held !L for RUN_NEED samples.
  logic lvl = 1'b1;
  logic x_m1 = 1'b1;
  logic x_m2 = 1'b1;
  int   run = 0;
  int   hold = 0;
  logic exp_flag = 1'b0;
  logic exp_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_edge(input logic k, input logic r);
    logic d;
    exp_flag  = 1'b0;
    exp_pulse = 1'b0;
    if (!r) begin
      lvl = 1'b1; run = 0; hold = 0; x_m1 = 1'b1; x_m2 = 1'b1;
    end else begin
      d    = x_m2;
      x_m2 = x_m1;
      x_m1 = k;
      if (d != lvl) begin
        run++;
        if (run == int'(RUN_NEED)) begin
          lvl = d; run = 0; hold = 0;
          exp_flag  = 1'b1;
          exp_pulse = ~d;
        end
      end else begin
`ifdef KEY_REPEAT_EN
        if (lvl == 1'b0) begin
          if (run == 0) begin
            hold++;
            if (hold == int'(RF) + 1 ||
                (hold > int'(RF) + 1 && (hold - int'(RF) - 1) % (int'(RP) + 1) == 0))
              exp_pulse = 1'b1;
          end else begin
            hold = 0;
          end
        end
`endif
        run = 0;
      end
    end
  endtask

  task automatic tick(input logic k, input logic r);
    @(negedge clock);
    key_in = k;
    rst_n  = r;
    @(posedge clock);
    edge_no++;
    model_edge(k, r);
    #1;
    check("key_flag", 32'(key_flag), 32'(exp_flag));
    check("press_pulse", 32'(press_pulse), 32'(exp_pulse));
    check("key_state", 32'(key_state), 32'(lvl));
    if (key_flag === 1'b1) begin
      flag_cnt++;
      last_flag_edge = edge_no;
    end
    if (press_pulse === 1'b1) begin
      pulse_cnt++;
      if (q == 4'd15) cout_cnt++;
      q = q + 4'd1;
    end
  endtask

  task automatic hold_key(input logic k, input int n);
    repeat (n) tick(k, 1'b1);
  endtask

  task automatic clear_counts();
    flag_cnt = 0;
    pulse_cnt = 0;
    last_flag_edge = 0;
  endtask

  initial begin
    logic v;
    int   len;
    rst_n  = 1'b0;
    key_in = 1'b1;

    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("reset_key_state", 32'(key_state), 32'd1);
    check("reset_key_flag", 32'(key_flag), 32'd0);
    hold_key(1'b1, 5);

    // Clean press: flag 12 edges after the first low sample.
    clear_counts();
    e0 = edge_no + 1;
    hold_key(1'b0, 40);
    check("press_latency", 32'(last_flag_edge), 32'(e0 + 12));
    check("press_flag_count", 32'(flag_cnt), 32'd1);
`ifdef KEY_REPEAT_EN
    check("press_pulse_count", 32'(pulse_cnt), 32'd3);
`else
    check("press_pulse_count", 32'(pulse_cnt), 32'd1);
`endif
    check("pressed_level", 32'(key_state), 32'd0);

    // Release.
    clear_counts();
    e0 = edge_no + 1;
    hold_key(1'b1, 20);
    check("release_latency", 32'(last_flag_edge), 32'(e0 + 12));
    check("release_flag_count", 32'(flag_cnt), 32'd1);
    check("release_pulse_count", 32'(pulse_cnt), 32'd0);
    check("released_level", 32'(key_state), 32'd1);

    // Bounce on press: only the final fall is reported.
    clear_counts();
    hold_key(1'b0, 5);
    hold_key(1'b1, 2);
    e0 = edge_no + 1;
    hold_key(1'b0, 30);
    check("bounce_latency", 32'(last_flag_edge), 32'(e0 + 12));
    check("bounce_flag_count", 32'(flag_cnt), 32'd1);
    check("bounce_pulse_count", 32'(pulse_cnt), 32'd1);
    hold_key(1'b1, 20);

    // Reset six clocks into the press filter, key still low.
    clear_counts();
    hold_key(1'b0, 8);
    tick(1'b0, 1'b0);
    hold_key(1'b0, 5);
    hold_key(1'b1, 5);
    check("midreset_flag_count", 32'(flag_cnt), 32'd0);
    check("midreset_level", 32'(key_state), 32'd1);
    e0 = edge_no + 1;
    hold_key(1'b0, 20);
    check("repress_latency", 32'(last_flag_edge), 32'(e0 + 12));
    check("repress_pulse_count", 32'(pulse_cnt), 32'd1);
    hold_key(1'b1, 20);

    // Twenty presses into a 4-bit counter.
    clear_counts();
    q = 4'd0;
    cout_cnt = 0;
    repeat (20) begin
      hold_key(1'b0, 15);
      hold_key(1'b1, 15);
    end
    check("chain_pulses", 32'(pulse_cnt), 32'd20);
    check("chain_q", 32'(q), 32'd4);
    check("chain_cout", 32'(cout_cnt), 32'd1);

`ifdef KEY_REPEAT_EN
    // Long hold: pulses at +0, +20, +25, ... +55 after the press is confirmed.
    clear_counts();
    e0 = edge_no + 1;
    hold_key(1'b0, 12 + 60);
    check("repeat_pulse_count", 32'(pulse_cnt), 32'd9);
    check("repeat_flag_count", 32'(flag_cnt), 32'd1);
    hold_key(1'b1, 20);
`endif

    // Random bouncy waveform with occasional resets.
    v = 1'b0;
    repeat (80) begin
      len = int'($urandom_range(1, 40));
      if ($urandom_range(0, 24) == 0) tick(v, 1'b0);
      hold_key(v, len);
      v = ~v;
    end
    hold_key(1'b1, 20);
    check("final_level", 32'(key_state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
